// File: rtl/ladybird_axi_arbiter.sv
// ladybird_axi_arbiter: two-master to one-slave AXI4-Lite arbiter with independent read and write channels.
// Define LADYBIRD_AXI_ARBITER_ROUND_ROBIN_EN for round-robin tie breaking; otherwise master 0 always wins ties.
module ladybird_axi_arbiter #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_arvalid,
  input  logic [AXI_ADDR_W-1:0]   m0_araddr,
  input  logic [2:0]              m0_arprot,
  output logic                    m0_arready,
  output logic                    m0_rvalid,
  output logic [AXI_DATA_W-1:0]   m0_rdata,
  output logic [1:0]              m0_rresp,
  input  logic                    m0_rready,
  input  logic                    m0_awvalid,
  input  logic [AXI_ADDR_W-1:0]   m0_awaddr,
  input  logic [2:0]              m0_awprot,
  output logic                    m0_awready,
  input  logic                    m0_wvalid,
  input  logic [AXI_DATA_W-1:0]   m0_wdata,
  input  logic [AXI_DATA_W/8-1:0] m0_wstrb,
  output logic                    m0_wready,
  output logic                    m0_bvalid,
  output logic [1:0]              m0_bresp,
  input  logic                    m0_bready,
  input  logic                    m1_arvalid,
  input  logic [AXI_ADDR_W-1:0]   m1_araddr,
  input  logic [2:0]              m1_arprot,
  output logic                    m1_arready,
  output logic                    m1_rvalid,
  output logic [AXI_DATA_W-1:0]   m1_rdata,
  output logic [1:0]              m1_rresp,
  input  logic                    m1_rready,
  input  logic                    m1_awvalid,
  input  logic [AXI_ADDR_W-1:0]   m1_awaddr,
  input  logic [2:0]              m1_awprot,
  output logic                    m1_awready,
  input  logic                    m1_wvalid,
  input  logic [AXI_DATA_W-1:0]   m1_wdata,
  input  logic [AXI_DATA_W/8-1:0] m1_wstrb,
  output logic                    m1_wready,
  output logic                    m1_bvalid,
  output logic [1:0]              m1_bresp,
  input  logic                    m1_bready,
  output logic                    s_arvalid,
  output logic [AXI_ADDR_W-1:0]   s_araddr,
  output logic [2:0]              s_arprot,
  input  logic                    s_arready,
  input  logic                    s_rvalid,
  input  logic [AXI_DATA_W-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  output logic                    s_rready,
  output logic                    s_awvalid,
  output logic [AXI_ADDR_W-1:0]   s_awaddr,
  output logic [2:0]              s_awprot,
  input  logic                    s_awready,
  output logic                    s_wvalid,
  output logic [AXI_DATA_W-1:0]   s_wdata,
  output logic [AXI_DATA_W/8-1:0] s_wstrb,
  input  logic                    s_wready,
  input  logic                    s_bvalid,
  input  logic [1:0]              s_bresp,
  output logic                    s_bready,
  output logic [1:0]              rd_grant,
  output logic [1:0]              wr_grant
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
  rd_state_t  r_rd_state;
  wr_state_t  r_wr_state;
  logic [1:0] r_rd_grant;
  logic [1:0] r_wr_grant;
  logic       r_aw_done;
  logic       r_w_done;
  logic       w_rd_win;
  logic       w_wr_win;
  logic       w_rd_sel;
  logic       w_wr_sel;
  logic       w_rd_addr;
  logic       w_rd_data;
  logic       w_wr_addr;
  logic       w_wr_resp;
  logic       w_aw_fire;
  logic       w_w_fire;
  // w_*_win is the index of the master that would be granted this cycle
`ifdef LADYBIRD_AXI_ARBITER_ROUND_ROBIN_EN
  logic r_rd_last;
  logic r_wr_last;
  assign w_rd_win = (m0_arvalid && m1_arvalid) ? ~r_rd_last : m1_arvalid;
  assign w_wr_win = (m0_awvalid && m1_awvalid) ? ~r_wr_last : m1_awvalid;
`else
  assign w_rd_win = ~m0_arvalid;
  assign w_wr_win = ~m0_awvalid;
`endif
  assign rd_grant  = r_rd_grant;
  assign wr_grant  = r_wr_grant;
  assign w_rd_sel  = r_rd_grant[1];
  assign w_wr_sel  = r_wr_grant[1];
  assign w_rd_addr = r_rd_state == R_ADDR;
  assign w_rd_data = r_rd_state == R_DATA;
  assign w_wr_addr = r_wr_state == W_ADDR;
  assign w_wr_resp = r_wr_state == W_RESP;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rd_grant <= 2'b00;
`ifdef LADYBIRD_AXI_ARBITER_ROUND_ROBIN_EN
      r_rd_last  <= 1'b1;
`endif
    end else begin
      case (r_rd_state)
        R_IDLE: if (m0_arvalid || m1_arvalid) begin
          r_rd_grant <= w_rd_win ? 2'b10 : 2'b01;
          r_rd_state <= R_ADDR;
`ifdef LADYBIRD_AXI_ARBITER_ROUND_ROBIN_EN
          r_rd_last  <= w_rd_win;
`endif
        end
        R_ADDR: if (s_arvalid && s_arready) r_rd_state <= R_DATA;
        R_DATA: if (s_rvalid && s_rready) begin
          r_rd_grant <= 2'b00;
          r_rd_state <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end
  assign s_arvalid  = w_rd_addr && (w_rd_sel ? m1_arvalid : m0_arvalid);
  assign s_araddr   = w_rd_sel ? m1_araddr : m0_araddr;
  assign s_arprot   = w_rd_sel ? m1_arprot : m0_arprot;
  assign m0_arready = w_rd_addr && r_rd_grant[0] && s_arready;
  assign m1_arready = w_rd_addr && r_rd_grant[1] && s_arready;
  assign m0_rvalid  = w_rd_data && r_rd_grant[0] && s_rvalid;
  assign m1_rvalid  = w_rd_data && r_rd_grant[1] && s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m1_rresp   = s_rresp;
  assign s_rready   = w_rd_data && (w_rd_sel ? m1_rready : m0_rready);
  assign w_aw_fire  = s_awvalid && s_awready;
  assign w_w_fire   = s_wvalid && s_wready;
  // AW and W complete independently; the done flags keep each from being reissued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_wr_grant <= 2'b00;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
`ifdef LADYBIRD_AXI_ARBITER_ROUND_ROBIN_EN
      r_wr_last  <= 1'b1;
`endif
    end else begin
      case (r_wr_state)
        W_IDLE: if (m0_awvalid || m1_awvalid) begin
          r_wr_grant <= w_wr_win ? 2'b10 : 2'b01;
          r_wr_state <= W_ADDR;
`ifdef LADYBIRD_AXI_ARBITER_ROUND_ROBIN_EN
          r_wr_last  <= w_wr_win;
`endif
        end
        W_ADDR: if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
          r_wr_state <= W_RESP;
        end else begin
          r_aw_done  <= r_aw_done || w_aw_fire;
          r_w_done   <= r_w_done || w_w_fire;
        end
        W_RESP: if (s_bvalid && s_bready) begin
          r_wr_grant <= 2'b00;
          r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end
  assign s_awvalid  = w_wr_addr && !r_aw_done && (w_wr_sel ? m1_awvalid : m0_awvalid);
  assign s_awaddr   = w_wr_sel ? m1_awaddr : m0_awaddr;
  assign s_awprot   = w_wr_sel ? m1_awprot : m0_awprot;
  assign s_wvalid   = w_wr_addr && !r_w_done && (w_wr_sel ? m1_wvalid : m0_wvalid);
  assign s_wdata    = w_wr_sel ? m1_wdata : m0_wdata;
  assign s_wstrb    = w_wr_sel ? m1_wstrb : m0_wstrb;
  assign m0_awready = w_wr_addr && !r_aw_done && r_wr_grant[0] && s_awready;
  assign m1_awready = w_wr_addr && !r_aw_done && r_wr_grant[1] && s_awready;
  assign m0_wready  = w_wr_addr && !r_w_done && r_wr_grant[0] && s_wready;
  assign m1_wready  = w_wr_addr && !r_w_done && r_wr_grant[1] && s_wready;
  assign m0_bvalid  = w_wr_resp && r_wr_grant[0] && s_bvalid;
  assign m1_bvalid  = w_wr_resp && r_wr_grant[1] && s_bvalid;
  assign m0_bresp   = s_bresp;
  assign m1_bresp   = s_bresp;
  assign s_bready   = w_wr_resp && (w_wr_sel ? m1_bready : m0_bready);
endmodule

// File: tb/tb_ladybird_axi_arbiter.sv
// tb_ladybird_axi_arbiter: directed self-checking bench with a reactive AXI4-Lite slave model.
module tb_ladybird_axi_arbiter;
  logic clk = 0, rst = 1;
  logic m0_arvalid = 0, m1_arvalid = 0, m0_rready = 0, m1_rready = 0;
  logic [31:0] m0_araddr = 0, m1_araddr = 0, m0_awaddr = 0, m1_awaddr = 0, m0_wdata = 0, m1_wdata = 0;
  logic [2:0] m0_arprot = 0, m1_arprot = 0, m0_awprot = 0, m1_awprot = 0;
  logic m0_awvalid = 0, m1_awvalid = 0, m0_wvalid = 0, m1_wvalid = 0, m0_bready = 0, m1_bready = 0;
  logic [3:0] m0_wstrb = 0, m1_wstrb = 0;
  logic m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_awready, m1_awready, m0_wready, m1_wready;
  logic m0_bvalid, m1_bvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0] m0_rresp, m1_rresp, m0_bresp, m1_bresp;
  logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [2:0] s_arprot, s_awprot;
  logic [3:0] s_wstrb;
  logic s_arready = 1, s_awready = 1, s_wready = 1;
  logic s_rvalid, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0] s_rresp, s_bresp;
  logic [1:0] rd_grant, wr_grant;
  int checks = 0, failures = 0, rlat = 2;

  always #5 clk = ~clk;

  ladybird_axi_arbiter #(.AXI_ADDR_W(32), .AXI_DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bready(m0_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .rd_grant(rd_grant), .wr_grant(wr_grant)
  );

  // Slave model: read data appears rlat cycles after AR; B follows one cycle after both AW and W
  logic r_pend, aw_got, w_got;
  int rcnt;
  logic [31:0] sl_araddr, sl_awaddr, sl_wdata;
  logic [3:0] sl_wstrb;
  always @(posedge clk) begin
    if (rst) begin
      s_rvalid <= 0; s_bvalid <= 0; s_rdata <= 0; s_rresp <= 0; s_bresp <= 0;
      r_pend <= 0; rcnt <= 0; aw_got <= 0; w_got <= 0;
    end else begin
      if (s_arvalid && s_arready) begin
        r_pend <= 1; rcnt <= rlat; sl_araddr <= s_araddr;
      end else if (r_pend) begin
        if (rcnt > 1) rcnt <= rcnt - 1;
        else begin
          r_pend <= 0; s_rvalid <= 1; s_rresp <= 2'b00;
          s_rdata <= (sl_araddr == 32'h8000_0000) ? 32'hDEAD_BEEF : ~sl_araddr;
        end
      end
      if (s_rvalid && s_rready) s_rvalid <= 0;
      if (s_awvalid && s_awready) begin aw_got <= 1; sl_awaddr <= s_awaddr; end
      if (s_wvalid && s_wready) begin w_got <= 1; sl_wdata <= s_wdata; sl_wstrb <= s_wstrb; end
      if ((aw_got || (s_awvalid && s_awready)) && (w_got || (s_wvalid && s_wready)) && !s_bvalid) begin
        s_bvalid <= 1; s_bresp <= 2'b00; aw_got <= 0; w_got <= 0;
      end
      if (s_bvalid && s_bready) s_bvalid <= 0;
    end
  end

  int n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, n_m1_rv = 0, n_m0_bv = 0, n_unstable = 0;
  logic overlap = 0, prev_stall = 0;
  logic [31:0] prev_addr = 0;
  logic [1:0] ar_log[$];
  always @(posedge clk) begin
    if (!rst) begin
      if (s_arvalid && s_arready) begin n_ar <= n_ar + 1; ar_log.push_back(rd_grant); end
      if (s_rvalid && s_rready) n_r <= n_r + 1;
      if (s_awvalid && s_awready) n_aw <= n_aw + 1;
      if (s_wvalid && s_wready) n_w <= n_w + 1;
      if (s_bvalid && s_bready) n_b <= n_b + 1;
      if (m1_rvalid) n_m1_rv <= n_m1_rv + 1;
      if (m0_bvalid) n_m0_bv <= n_m0_bv + 1;
      if (rd_grant == 2'b01 && wr_grant == 2'b10) overlap <= 1;
      if (prev_stall && s_araddr !== prev_addr) n_unstable <= n_unstable + 1;
    end
    prev_stall <= s_arvalid && !s_arready;
    prev_addr <= s_araddr;
  end

  task automatic set_ar(input int m, input logic v, input logic [31:0] a);
    if (m == 0) begin m0_arvalid = v; m0_araddr = a; end
    else begin m1_arvalid = v; m1_araddr = a; end
  endtask

  task automatic set_aw(input int m, input logic v, input logic [31:0] a);
    if (m == 0) begin m0_awvalid = v; m0_awaddr = a; end
    else begin m1_awvalid = v; m1_awaddr = a; end
  endtask

  task automatic set_w(input int m, input logic v, input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin m0_wvalid = v; m0_wdata = d; m0_wstrb = s; end
    else begin m1_wvalid = v; m1_wdata = d; m1_wstrb = s; end
  endtask

  // Called just after a falling edge; returns just after a falling edge
  task automatic do_read(input int m, input logic [31:0] a, input int rdly,
                         output logic [31:0] d, output logic [1:0] r);
    int n = 0, seen = 0;
    logic hs = 0, rr;
    d = 'x; r = 'x;
    set_ar(m, 1, a);
    while (!hs && n < 100) begin
      #1 hs = (m == 0) ? m0_arready : m1_arready;
      @(posedge clk); @(negedge clk); n++;
    end
    set_ar(m, 0, a);
    checks++;
    if (!hs) begin failures++; $display("FAIL rd_addr_timeout m%0d got=no_arready expected=arready", m); end
    hs = 0; n = 0;
    while (!hs && n < 100) begin
      rr = seen >= rdly;
      if (m == 0) m0_rready = rr; else m1_rready = rr;
      #1 if ((m == 0) ? m0_rvalid : m1_rvalid) begin
        if (rr) begin hs = 1; d = (m == 0) ? m0_rdata : m1_rdata; r = (m == 0) ? m0_rresp : m1_rresp; end
        else seen++;
      end
      @(posedge clk); @(negedge clk); n++;
    end
    if (m == 0) m0_rready = 0; else m1_rready = 0;
    checks++;
    if (!hs) begin failures++; $display("FAIL rd_data_timeout m%0d got=no_rvalid expected=rvalid", m); end
  endtask

  task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int adly, output logic [1:0] b);
    int c = 0;
    logic ad = 0, wd = 0, ah, wh, av, hs = 0;
    b = 'x;
    while (!(ad && wd) && c < 100) begin
      av = !ad && c >= adly;
      set_aw(m, av, a); set_w(m, !wd, d, s);
      #1 ah = av && ((m == 0) ? m0_awready : m1_awready);
      wh = !wd && ((m == 0) ? m0_wready : m1_wready);
      @(posedge clk); @(negedge clk);
      ad = ad | ah; wd = wd | wh; c++;
    end
    set_aw(m, 0, a); set_w(m, 0, d, s);
    checks++;
    if (!(ad && wd)) begin failures++; $display("FAIL wr_addr_timeout m%0d got aw=%0b w=%0b expected=11", m, ad, wd); end
    c = 0;
    if (m == 0) m0_bready = 1; else m1_bready = 1;
    while (!hs && c < 100) begin
      #1 if ((m == 0) ? m0_bvalid : m1_bvalid) begin hs = 1; b = (m == 0) ? m0_bresp : m1_bresp; end
      @(posedge clk); @(negedge clk); c++;
    end
    if (m == 0) m0_bready = 0; else m1_bready = 0;
    checks++;
    if (!hs) begin failures++; $display("FAIL wr_resp_timeout m%0d got=no_bvalid expected=bvalid", m); end
  endtask

  task automatic test_reset;
    logic [13:0] v;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    v = {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready, m1_arready, m0_awready,
         m1_awready, m0_wready, m1_wready, m0_rvalid, m1_rvalid, m0_bvalid | m1_bvalid};
    checks++;
    if (rd_grant !== 2'b00) begin failures++; $display("FAIL reset_rd_grant got=%b expected=00", rd_grant); end
    checks++;
    if (wr_grant !== 2'b00) begin failures++; $display("FAIL reset_wr_grant got=%b expected=00", wr_grant); end
    checks++;
    if (v !== 14'd0) begin failures++; $display("FAIL reset_handshakes got=%b expected=0", v); end
  endtask

  task automatic test_single_read;
    logic [31:0] d;
    logic [1:0] r, g;
    logic [31:0] sa;
    int m1rv = n_m1_rv;
    fork
      do_read(0, 32'h8000_0000, 0, d, r);
      begin @(posedge clk); #2 g = rd_grant; sa = s_araddr; end
    join
    checks++;
    if (g !== 2'b01) begin failures++; $display("FAIL single_grant got=%b expected=01", g); end
    checks++;
    if (sa !== 32'h8000_0000) begin failures++; $display("FAIL single_araddr got=%h expected=80000000", sa); end
    checks++;
    if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata got=%h expected=deadbeef", d); end
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL single_rresp got=%b expected=00", r); end
    checks++;
    if (rd_grant !== 2'b00) begin failures++; $display("FAIL single_grant_release got=%b expected=00", rd_grant); end
    checks++;
    if (n_m1_rv !== m1rv) begin failures++; $display("FAIL single_m1_isolation got=%0d expected=%0d", n_m1_rv, m1rv); end
  endtask

  task automatic rd_stream(input int m);
    logic [31:0] a, d;
    logic [1:0] r;
    for (int i = 0; i < 4; i++) begin
      a = 32'h8000_2000 + 32'(m) * 32'h100 + 32'(i) * 32'd4;
      do_read(m, a, 0, d, r);
      checks++;
      if (d !== ~a) begin failures++; $display("FAIL contention_rdata m%0d got=%h expected=%h", m, d, ~a); end
    end
  endtask

  task automatic test_contention;
    logic [1:0] e;
    ar_log.delete();
    fork
      rd_stream(0);
      rd_stream(1);
    join
    checks++;
    if (ar_log.size() !== 8) begin failures++; $display("FAIL contention_count got=%0d expected=8", ar_log.size()); end
    for (int i = 0; i < 8 && i < ar_log.size(); i++) begin
`ifdef LADYBIRD_AXI_ARBITER_ROUND_ROBIN_EN
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      e = (i < 4) ? 2'b01 : 2'b10;
`endif
      checks++;
      if (ar_log[i] !== e) begin failures++; $display("FAIL contention_order[%0d] got=%b expected=%b", i, ar_log[i], e); end
    end
  endtask

  task automatic test_write_w_first;
    logic [1:0] b;
    int aw0 = n_aw, w0 = n_w, m0bv = n_m0_bv;
    do_write(1, 32'h8000_1000, 32'h1234_5678, 4'hF, 3, b);
    checks++;
    if (n_aw - aw0 !== 1) begin failures++; $display("FAIL write_aw_count got=%0d expected=1", n_aw - aw0); end
    checks++;
    if (n_w - w0 !== 1) begin failures++; $display("FAIL write_w_count got=%0d expected=1", n_w - w0); end
    checks++;
    if (sl_awaddr !== 32'h8000_1000) begin failures++; $display("FAIL write_awaddr got=%h expected=80001000", sl_awaddr); end
    checks++;
    if ({sl_wstrb, sl_wdata} !== {4'hF, 32'h1234_5678}) begin
      failures++; $display("FAIL write_wdata got=%h/%h expected=f/12345678", sl_wstrb, sl_wdata);
    end
    checks++;
    if (b !== 2'b00) begin failures++; $display("FAIL write_bresp got=%b expected=00", b); end
    checks++;
    if (wr_grant !== 2'b00) begin failures++; $display("FAIL write_grant_release got=%b expected=00", wr_grant); end
    checks++;
    if (n_m0_bv !== m0bv) begin failures++; $display("FAIL write_m0_isolation got=%0d expected=%0d", n_m0_bv, m0bv); end
  endtask

  task automatic test_concurrent;
    logic [31:0] d;
    logic [1:0] r, b;
    @(negedge clk);
    overlap = 0;
    fork
      do_read(0, 32'h8000_3000, 0, d, r);
      do_write(1, 32'h8000_4000, 32'hCAFE_F00D, 4'h3, 0, b);
    join
    checks++;
    if (overlap !== 1'b1) begin failures++; $display("FAIL concurrent_overlap got=%b expected=1", overlap); end
    checks++;
    if (d !== ~32'h8000_3000) begin failures++; $display("FAIL concurrent_rdata got=%h expected=%h", d, ~32'h8000_3000); end
    checks++;
    if ({sl_wstrb, sl_wdata, b} !== {4'h3, 32'hCAFE_F00D, 2'b00}) begin
      failures++; $display("FAIL concurrent_write got=%h/%h/%b expected=3/cafef00d/00", sl_wstrb, sl_wdata, b);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    logic [1:0] r;
    int ar0 = n_ar, r0 = n_r, u0 = n_unstable;
    s_arready = 0;
    fork
      do_read(0, 32'h8000_5000, 3, d, r);
      begin repeat (6) @(posedge clk); @(negedge clk); s_arready = 1; end
    join
    checks++;
    if (n_unstable !== u0) begin failures++; $display("FAIL bp_araddr_stable got=%0d expected=%0d", n_unstable, u0); end
    checks++;
    if (n_ar - ar0 !== 1) begin failures++; $display("FAIL bp_ar_count got=%0d expected=1", n_ar - ar0); end
    checks++;
    if (n_r - r0 !== 1) begin failures++; $display("FAIL bp_r_count got=%0d expected=1", n_r - r0); end
    checks++;
    if (d !== ~32'h8000_5000) begin failures++; $display("FAIL bp_rdata got=%h expected=%h", d, ~32'h8000_5000); end
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] d;
    logic [1:0] r;
    logic [4:0] v;
    rlat = 8;
    set_ar(0, 1, 32'h8000_6000);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    set_ar(0, 0, 32'h8000_6000);
    m0_rready = 1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({rd_grant, m0_rvalid} !== 3'b010) begin failures++; $display("FAIL midrst_pre got=%b expected=010", {rd_grant, m0_rvalid}); end
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0; m0_rready = 0; rlat = 2;
    v = {s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_arready};
    checks++;
    if (rd_grant !== 2'b00) begin failures++; $display("FAIL midrst_grant got=%b expected=00", rd_grant); end
    checks++;
    if (v !== 5'd0) begin failures++; $display("FAIL midrst_valids got=%b expected=00000", v); end
    do_read(1, 32'h8000_7000, 0, d, r);
    checks++;
    if ({d, r} !== {~32'h8000_7000, 2'b00}) begin failures++; $display("FAIL midrst_m1_read got=%h/%b expected=%h/00", d, r, ~32'h8000_7000); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_w_first();
    test_concurrent();
    test_backpressure();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ladybird_axi_arbiter.md
# ladybird_axi_arbiter

Two-master to one-slave AXI4-Lite arbiter between the core's instruction-fetch port (master 0) and data port (master 1) and the single memory/peripheral AXI slave, e.g. the simulation memory. Read and write channels are arbitrated independently. Each channel carries exactly one outstanding transaction and holds its grant until the response handshake completes. Address, data and response are routed without modification.

## Interface
Parameters:
- AXI_ADDR_W, 32, address width of all AR/AW channels
- AXI_DATA_W, 32, data width of all R/W channels; WSTRB is AXI_DATA_W/8

Ports (prefix m0_/m1_ = master side, s_ = slave side; each group is one line per master):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m{0,1}_arvalid, m{0,1}_araddr[AXI_ADDR_W], m{0,1}_arprot[3]  in  master read address
- m{0,1}_arready  out  1  read address accepted
- m{0,1}_rvalid, m{0,1}_rdata[AXI_DATA_W], m{0,1}_rresp[2]  out  read data
- m{0,1}_rready  in  1
- m{0,1}_awvalid, m{0,1}_awaddr, m{0,1}_awprot, m{0,1}_wvalid, m{0,1}_wdata, m{0,1}_wstrb  in  write address/data
- m{0,1}_awready, m{0,1}_wready  out  1
- m{0,1}_bvalid, m{0,1}_bresp[2]  out  write response
- m{0,1}_bready  in  1
- s_ar*/s_aw*/s_w* outputs and s_r*/s_b* inputs: mirror of one master port with opposite directions
- rd_grant  out  2  one-hot current read owner; 0 = idle
- wr_grant  out  2  one-hot current write owner; 0 = idle

## Operation
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any m*_arvalid, pick a winner, register rd_grant, go to R_ADDR.
  - R_ADDR: s_ar* = winner's AR; winner's arready = s_arready. On s_arvalid&s_arready go to R_DATA.
  - R_DATA: winner's r* = s_r*; s_rready = winner's rready. On s_rvalid&s_rready clear rd_grant and go to R_IDLE.
- Write FSM states: W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: arbitrate on m*_awvalid.
  - W_ADDR: forward the winner's AW and W independently. Registered flags aw_done and w_done record each handshake. s_awvalid is masked once aw_done; s_wvalid is masked once w_done. Move to W_RESP when both are done, including the cycle both complete.
  - W_RESP: route B to the winner; on s_bvalid&s_bready go to W_IDLE.
- Loser isolation: a non-granted master sees arready/awready/wready/rvalid/bvalid = 0.
- Slave outputs when idle: s_*valid = 0 and s_rready = s_bready = 0. Addr/data outputs are don't-care.
- Read and write FSMs are independent. The same master may own both channels at once, and the two masters may own opposite channels concurrently.
- A master that drops arvalid/awvalid before its handshake violates AXI. Behaviour is undefined; the bench does not stimulate it.

## Timing
- Arbitration latency: one cycle. A request first seen in *_IDLE at edge N drives s_arvalid/s_awvalid from edge N+1.
- Combinational paths: slave ready→master ready and response valid→master valid. No added cycles in R_ADDR, W_ADDR, R_DATA or W_RESP.
- Minimum read occupancy: 3 cycles (IDLE, ADDR, DATA). Back-to-back grants therefore have at least 1 idle cycle between them.
- Reset (rst=1 at an edge) puts both FSMs in *_IDLE, sets rd_grant=wr_grant=0, clears aw_done/w_done, and sets the priority pointers to "last = master 1", so master 0 wins first. All master valid/ready outputs and slave valid/ready outputs are 0 from the next cycle.
- Reset mid-transaction abandons the transaction without a response; the slave must be reset together with the arbiter.

## Configuration
- LADYBIRD_AXI_ARBITER_ROUND_ROBIN_EN defined: each channel keeps a 1-bit last-winner pointer, updated on grant. On a simultaneous request, the master that did not win last is granted. A single requester always wins.
- Not defined: fixed priority. Master 0 (instruction fetch) always wins ties. The pointer logic is not compiled in.

## Test plan
- Single read: m0 ARADDR=0x80000000; slave returns RDATA=0xDEADBEEF after 2 cycles -> m0_rdata=0xDEADBEEF, RRESP=0, rd_grant 01→00, m1 sees no rvalid.
- Contention: m0 and m1 assert arvalid in the same cycle, 4 reads each.
  - With ROUND_ROBIN_EN: grant order m0,m1,m0,m1,...
  - Without: all four m0 reads complete before any m1 read.
- Write, W before AW: m1 WDATA=0x12345678 with WSTRB=0xF, then AW 0x80001000 three cycles later -> exactly one s_w and one s_aw handshake, m1 gets bvalid with BRESP=0, wr_grant returns to 00.
- Concurrent channels: m0 read and m1 write issued in the same cycle -> both complete with overlapping slave activity; rd_grant=01 and wr_grant=10 simultaneously.
- Backpressure: s_arready low for 5 cycles and m0_rready low for 3 cycles -> s_araddr stable, no duplicate handshake, single data beat delivered.
- Reset mid-R_DATA: assert rst for 1 cycle -> next cycle rd_grant=0 and all valids 0; a subsequent m1 read completes normally.
